// File: rtl/uart_transmitter.sv
// uart_transmitter: double-buffered 8N1 UART transmitter with a valid/ready byte input
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       tx_busy
);
    localparam int T  = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(T - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_valid_q, hold_valid_d;
    logic          tx_q, tx_d;
    logic          bit_end, load;

    assign bit_end       = cnt_q == T_LAST;
    assign data_in_ready = !hold_valid_q;
    assign tx_busy       = (state_q != IDLE) || hold_valid_q;
    assign serial_out    = tx_q;

    // Next-state: frame sequencing, holding-register hand-off and byte acceptance
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;
        case (state_q)
            IDLE: load = hold_valid_q;
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end && bit_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else if (bit_end) begin
                    bit_d   = bit_q + 3'd1;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            default: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    load    = hold_valid_q;
                    state_d = IDLE;
                end
            end
        endcase
        // A waiting byte starts its frame straight away, also from the last stop cycle
        if (load) begin
            state_d      = START;
            shift_d      = hold_data_q;
            hold_valid_d = 1'b0;
            tx_d         = 1'b0;
            cnt_d        = '0;
        end
        // Only an empty holding register accepts, so acceptance never meets a transfer
        if (data_in_valid && !hold_valid_q) begin
            hold_data_d  = data_in;
            hold_valid_d = 1'b1;
        end
    end

    // State registers; reset aborts any frame and returns the line high at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            hold_data_q  <= 8'd0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of the UART transmitter at default and divide-by-4 rates
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       valid = 1'b0;
    logic       sel = 1'b0;
    logic       so_a, rdy_a, bsy_a, so_b, rdy_b, bsy_b;
    logic       so, rdy, bsy;
    int         tper;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         hi_cnt = 0;
    int         busy_bad = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to time frame starts
    always @(posedge clk) cyc <= cyc + 1;

    assign so  = sel ? so_b : so_a;
    assign rdy = sel ? rdy_b : rdy_a;
    assign bsy = sel ? bsy_b : bsy_a;
    assign tper = sel ? 4 : 434;

    uart_transmitter u_a (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(valid && !sel),
        .data_in_ready(rdy_a), .serial_out(so_a), .tx_busy(bsy_a)
    );

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(250)) u_b (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(valid && sel),
        .data_in_ready(rdy_b), .serial_out(so_b), .tx_busy(bsy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a byte with valid held; returns at the sample just after the accepting edge
    task automatic send(input logic [7:0] b);
        logic r;
        data_in = b;
        valid   = 1'b1;
        for (int k = 0; k < 30000; k++) begin
            r = rdy;
            step();
            if (r) return;
        end
        check("send timeout", 1, 0);
    endtask

    task automatic wait_start(input string tag);
        for (int k = 0; k < 20 * tper + 10; k++) begin
            if (so === 1'b0) return;
            step();
        end
        check(tag, 1, 0);
    endtask

    // Expects the frame to begin at the current sample; checks every cycle of all ten bits
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] f;
        int bad;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            for (int c = 0; c < tper; c++) begin
                if (so !== f[i]) bad++;
                if (bsy !== 1'b1) busy_bad++;
                if (rdy === 1'b1) hi_cnt++;
                step();
            end
            check($sformatf("%s bit%0d bad cycles", tag, i), bad, 0);
        end
    endtask

    int t1, t2, bad;

    initial begin
        repeat (2) step();
        check("reset so_a", so_a, 1);
        check("reset rdy_a", rdy_a, 1);
        check("reset bsy_a", bsy_a, 0);
        check("reset so_b", so_b, 1);
        check("reset rdy_b", rdy_b, 1);
        check("reset bsy_b", bsy_b, 0);
        rst = 1'b1;
        step();

        bad = 0;
        repeat (10000) begin
            if (so !== 1'b1 || bsy !== 1'b0 || rdy !== 1'b1) bad++;
            step();
        end
        check("idle bad cycles", bad, 0);

        send(8'hA5);
        valid = 1'b0;
        check("a5 so at accept", so, 1);
        check("a5 rdy at accept", rdy, 0);
        check("a5 bsy at accept", bsy, 1);
        step();
        busy_bad = 0;
        expect_frame(8'hA5, "a5");
        check("a5 busy during frame", busy_bad, 0);
        check("a5 bsy after", bsy, 0);
        check("a5 so after", so, 1);
        check("a5 rdy after", rdy, 1);

        step();
        fork
            begin
                send(8'h55);
                send(8'h0F);
                valid = 1'b0;
            end
            begin
                wait_start("b2b start timeout");
                t1 = cyc;
                hi_cnt = 0;
                expect_frame(8'h55, "b2b 55");
                check("b2b ready high cycles in frame1", hi_cnt, 1);
                t2 = cyc;
                check("b2b start spacing", t2 - t1, 4340);
                expect_frame(8'h0F, "b2b 0f");
                check("b2b bsy after", bsy, 0);
            end
        join

        step();
        fork
            begin
                send(8'h01);
                send(8'h02);
                send(8'h03);
                valid = 1'b0;
            end
            begin
                wait_start("bp start timeout");
                hi_cnt = 0;
                expect_frame(8'h01, "bp 01");
                check("bp ready high frame1", hi_cnt, 1);
                hi_cnt = 0;
                expect_frame(8'h02, "bp 02");
                check("bp ready high frame2", hi_cnt, 1);
                expect_frame(8'h03, "bp 03");
                check("bp bsy after", bsy, 0);
                bad = 0;
                repeat (500) begin
                    if (so !== 1'b1) bad++;
                    step();
                end
                check("bp no extra frame", bad, 0);
            end
        join

        send(8'h00);
        valid = 1'b0;
        step();
        repeat (1999) step();
        check("rst line low before reset", so, 0);
        rst = 1'b0;
        #1;
        check("rst so immediate", so, 1);
        check("rst rdy immediate", rdy, 1);
        check("rst bsy immediate", bsy, 0);
        repeat (3) step();
        check("rst so held", so, 1);
        rst = 1'b1;
        step();
        check("rst so resumed idle", so, 1);
        check("rst bsy resumed idle", bsy, 0);
        send(8'hFF);
        valid = 1'b0;
        step();
        expect_frame(8'hFF, "post-rst ff");
        check("post-rst bsy after", bsy, 0);

        sel = 1'b1;
        step();
        send(8'h80);
        valid = 1'b0;
        step();
        busy_bad = 0;
        expect_frame(8'h80, "div4 80");
        check("div4 busy during frame", busy_bad, 0);
        check("div4 bsy after", bsy, 0);
        check("div4 so after", so, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
